card_flip_renderer: RTL and testbench

Renders one memory-game card sprite on the 640x480 VGA raster, with a per-card reveal/hide wipe animation driven by a frame tick. Parametrised successor to the fixed 83x83, 4x4-grid card renderer: grid, geometry, colour depth and animation speed are all generics. One instance per card; its cardon/rgb outputs feed the pixel mux ahead of the VGA output stage.

---
 rtl/card_pkg.sv | 29 ++
 rtl/card_geom.sv | 41 ++++
 rtl/card_flip_renderer.sv | 168 ++++++++++++++++
 tb/tb_card_flip_renderer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared definitions for the memory-game card renderers: FSM state encoding,
// default grid geometry and raster coordinate width.
package card_pkg;

  // Raster coordinate width; all geometry arithmetic wraps at this width.
  localparam int VGA_W = 10;

  // Default grid placement on the 640x480 raster.
  localparam int DEF_ORIGIN_X = 130;
  localparam int DEF_ORIGIN_Y = 70;
  localparam int DEF_PITCH_X  = 100;
  localparam int DEF_PITCH_Y  = 100;

  typedef enum logic [2:0] {
    ST_HIDDEN    = 3'd0,
    ST_REVEALING = 3'd1,
    ST_SHOWN     = 3'd2,
    ST_HIDING    = 3'd3,
    ST_MATCHED   = 3'd4
  } card_state_t;

  // Advance the wipe position by one step, saturating at the 8-bit ceiling.
  function automatic logic [7:0] wipe_advance(input logic [7:0] w, input int step);
    int sum;
    sum = int'(w) + step;
    return (sum > 255) ? 8'hFF : 8'(sum);
  endfunction

endpackage

// File: rtl/card_geom.sv
// Card placement: maps a grid slot to its pixel box and reports whether the
// current raster position falls inside it, plus the offsets into the sprite.
module card_geom
  import card_pkg::*;
#(
  parameter int CARD_W    = 83,
  parameter int CARD_H    = 83,
  parameter int GRID_COLS = 4,
  parameter int GRID_ROWS = 4,
  parameter int ORIGIN_X  = DEF_ORIGIN_X,
  parameter int ORIGIN_Y  = DEF_ORIGIN_Y,
  parameter int PITCH_X   = DEF_PITCH_X,
  parameter int PITCH_Y   = DEF_PITCH_Y,
  parameter int POS_W     = 4
) (
  input  logic [POS_W-1:0] pos,
  input  logic [9:0]       h_count,
  input  logic [9:0]       v_count,
  output logic [9:0]       x_l,
  output logic [9:0]       y_t,
  output logic             in_box,
  output logic [9:0]       col_off,
  output logic [9:0]       row_off
);

  logic [9:0] x_r;
  logic [9:0] y_b;

  // Box corners and raster offsets, all in wrapping 10-bit arithmetic.
  always_comb begin
    x_l     = VGA_W'(ORIGIN_X + (int'(pos) % GRID_COLS) * PITCH_X);
    y_t     = VGA_W'(ORIGIN_Y + (int'(pos) / GRID_COLS) * PITCH_Y);
    x_r     = x_l + VGA_W'(CARD_W - 1);
    y_b     = y_t + VGA_W'(CARD_H - 1);
    in_box  = (h_count >= x_l) && (h_count <= x_r) &&
              (v_count >= y_t) && (v_count <= y_b);
    col_off = h_count - x_l;
    row_off = v_count - y_t;
  end

endmodule

// File: rtl/card_flip_renderer.sv
// One memory-game card: draws the back or face sprite at its grid slot and
// animates reveal/hide as a left-to-right wipe advanced by the frame tick.
// Build option: CARD_MATCH_DIM_EN checkerboard-dims a matched card.
module card_flip_renderer
  import card_pkg::*;
#(
  parameter int CARD_W    = 83,
  parameter int CARD_H    = 83,
  parameter int GRID_COLS = 4,
  parameter int GRID_ROWS = 4,
  parameter int ORIGIN_X  = DEF_ORIGIN_X,
  parameter int ORIGIN_Y  = DEF_ORIGIN_Y,
  parameter int PITCH_X   = DEF_PITCH_X,
  parameter int PITCH_Y   = DEF_PITCH_Y,
  parameter int RGB_W     = 3,
  parameter int WIPE_STEP = 11
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [$clog2(GRID_COLS*GRID_ROWS)-1:0]     pos,
  input  logic [9:0]                                 HCount,
  input  logic [9:0]                                 VCount,
  input  logic                                       frame_tick,
  input  logic                                       flip_req,
  input  logic                                       hide_req,
  input  logic                                       match_req,
  output logic [$clog2(CARD_H)-1:0]                  rom_row,
  input  logic [CARD_W*RGB_W-1:0]                    back_data,
  input  logic [CARD_W*RGB_W-1:0]                    face_data,
  output logic                                       cardon,
  output logic [RGB_W-1:0]                           rgb,
  output logic                                       busy,
  output logic [2:0]                                 state
);

  localparam int POS_W = $clog2(GRID_COLS*GRID_ROWS);
  localparam int ROW_W = $clog2(CARD_H);
  localparam int PIX_W = CARD_W * RGB_W;

  // Requests are single-cycle pulses with no ready/ack: a pulse is consumed
  // only if the current state accepts it, otherwise it is dropped.

  card_state_t st;
  logic [7:0]  wipe;
  logic [7:0]  wipe_adv;
  logic        wipe_done;

  logic [9:0]  x_l, y_t, col_off, row_off;
  logic        in_box;
  logic        unused_geom;

  logic [PIX_W-1:0] back_sh, face_sh;
  logic [RGB_W-1:0] back_pix, face_pix, pix_sel;
  logic             wipe_hit, use_face;

  card_geom #(
    .CARD_W(CARD_W), .CARD_H(CARD_H),
    .GRID_COLS(GRID_COLS), .GRID_ROWS(GRID_ROWS),
    .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y),
    .PITCH_X(PITCH_X), .PITCH_Y(PITCH_Y),
    .POS_W(POS_W)
  ) u_geom (
    .pos(pos), .h_count(HCount), .v_count(VCount),
    .x_l(x_l), .y_t(y_t), .in_box(in_box),
    .col_off(col_off), .row_off(row_off)
  );

  assign rom_row     = row_off[ROW_W-1:0];
  assign unused_geom = ^{x_l, y_t, row_off[9:ROW_W]};
  assign state       = st;

  // Saturating wipe step and its completion test.
  always_comb begin
    wipe_adv  = wipe_advance(wipe, WIPE_STEP);
    wipe_done = int'(wipe_adv) >= CARD_W;
  end

  // Pick the sprite column for this pixel and apply the wipe split.
  always_comb begin
    back_sh  = back_data >> (int'(col_off) * RGB_W);
    face_sh  = face_data >> (int'(col_off) * RGB_W);
    back_pix = back_sh[RGB_W-1:0];
    face_pix = face_sh[RGB_W-1:0];
    wipe_hit = col_off < {2'b00, wipe};
    case (st)
      ST_REVEALING: use_face = wipe_hit;
      ST_SHOWN:     use_face = 1'b1;
      ST_HIDING:    use_face = ~wipe_hit;
      ST_MATCHED:   use_face = 1'b1;
      default:      use_face = 1'b0;
    endcase
    pix_sel = use_face ? face_pix : back_pix;
`ifdef CARD_MATCH_DIM_EN
    if ((st == ST_MATCHED) && (HCount[0] ^ VCount[0]))
      pix_sel = '0;
`endif
  end

  // One-cycle pixel pipeline stage; black outside the card box.
  always_ff @(posedge clk) begin
    if (reset) begin
      cardon <= 1'b0;
      rgb    <= '0;
    end else begin
      cardon <= in_box;
      rgb    <= in_box ? pix_sel : '0;
    end
  end

  // Card lifecycle FSM with wipe position and registered busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      st   <= ST_HIDDEN;
      wipe <= 8'd0;
      busy <= 1'b0;
    end else begin
      case (st)
        ST_HIDDEN: begin
          if (flip_req) begin
            st   <= ST_REVEALING;
            wipe <= 8'd0;
            busy <= 1'b1;
          end
        end
        ST_REVEALING: begin
          if (frame_tick) begin
            if (wipe_done) begin
              st   <= ST_SHOWN;
              wipe <= 8'd0;
              busy <= 1'b0;
            end else begin
              wipe <= wipe_adv;
            end
          end
        end
        ST_SHOWN: begin
          if (hide_req) begin
            st   <= ST_HIDING;
            wipe <= 8'd0;
            busy <= 1'b1;
          end else if (match_req) begin
            st <= ST_MATCHED;
          end
        end
        ST_HIDING: begin
          if (frame_tick) begin
            if (wipe_done) begin
              st   <= ST_HIDDEN;
              wipe <= 8'd0;
              busy <= 1'b0;
            end else begin
              wipe <= wipe_adv;
            end
          end
        end
        ST_MATCHED: begin
          st <= ST_MATCHED;
        end
        default: begin
          st   <= ST_HIDDEN;
          wipe <= 8'd0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_flip_renderer.sv
// Bench for card_flip_renderer: directed walk through the card lifecycle and
// pixel rules, then randomized requests/ticks/pixels against a reference model.
module tb_card_flip_renderer;

  localparam int CARD_W = 83;
  localparam int CARD_H = 83;
  localparam int COLS   = 4;
  localparam int OX     = 130;
  localparam int OY     = 70;
  localparam int PX     = 100;
  localparam int PY     = 100;
  localparam int RGB_W  = 3;
  localparam int STEP   = 11;
  localparam int PIX_W  = CARD_W * RGB_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]       pos = 4'd5;
  logic [9:0]       h_count = '0, v_count = '0;
  logic             frame_tick = 1'b0, flip_req = 1'b0, hide_req = 1'b0, match_req = 1'b0;
  logic [6:0]       rom_row;
  logic [PIX_W-1:0] back_data, face_data;
  logic             cardon, busy;
  logic [RGB_W-1:0] rgb;
  logic [2:0]       state;

  logic [PIX_W-1:0] back_rom [CARD_H];
  logic [PIX_W-1:0] face_rom [CARD_H];

  card_flip_renderer dut (
    .clk(clk), .reset(reset), .pos(pos), .HCount(h_count), .VCount(v_count),
    .frame_tick(frame_tick), .flip_req(flip_req), .hide_req(hide_req),
    .match_req(match_req), .rom_row(rom_row), .back_data(back_data),
    .face_data(face_data), .cardon(cardon), .rgb(rgb), .busy(busy), .state(state)
  );

  // Sprite ROMs answer combinationally on rom_row.
  always_comb begin
    int idx;
    idx = int'(rom_row);
    back_data = (idx < CARD_H) ? back_rom[idx] : '0;
    face_data = (idx < CARD_H) ? face_rom[idx] : '0;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // States: 0 hidden, 1 revealing, 2 shown, 3 hiding, 4 matched.
  int m_st = 0;
  int m_w  = 0;

  function automatic void model_step(input bit f, input bit hd, input bit m, input bit t);
    int nw;
    nw = m_w + STEP;
    if (nw > 255) nw = 255;
    if (m_st == 0 && f) begin
      m_st = 1; m_w = 0;
    end else if ((m_st == 1 || m_st == 3) && t) begin
      if (nw >= CARD_W) begin
        m_st = (m_st == 1) ? 2 : 0; m_w = 0;
      end else m_w = nw;
    end else if (m_st == 2 && hd) begin
      m_st = 3; m_w = 0;
    end else if (m_st == 2 && m) begin
      m_st = 4;
    end
  endfunction

  function automatic int box_x(input int p); return OX + (p % COLS) * PX; endfunction
  function automatic int box_y(input int p); return OY + (p / COLS) * PY; endfunction

  function automatic bit model_on(input int p, input int h, input int v);
    return (h >= box_x(p)) && (h < box_x(p) + CARD_W) &&
           (v >= box_y(p)) && (v < box_y(p) + CARD_H);
  endfunction

  function automatic int model_rgb(input int p, input int h, input int v);
    int c, r;
    bit face;
    logic [PIX_W-1:0] line;
    if (!model_on(p, h, v)) return 0;
    c = h - box_x(p);
    r = v - box_y(p);
    face = (m_st == 2) || (m_st == 4) || (m_st == 1 && c < m_w) || (m_st == 3 && c >= m_w);
`ifdef CARD_MATCH_DIM_EN
    if (m_st == 4 && ((h % 2) != (v % 2))) return 0;
`endif
    line = face ? face_rom[r] : back_rom[r];
    return int'(line[c*RGB_W +: RGB_W]);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic check_fsm(input string tag);
    check({tag, ".state"}, state, m_st);
    check({tag, ".busy"}, busy, (m_st == 1 || m_st == 3));
    check({tag, ".wipe"}, dut.wipe, m_w);
  endtask

  task automatic apply(input string tag, input bit f, input bit hd, input bit m, input bit t);
    flip_req = f; hide_req = hd; match_req = m; frame_tick = t;
    step();
    flip_req = 0; hide_req = 0; match_req = 0; frame_tick = 0;
    model_step(f, hd, m, t);
    check_fsm(tag);
  endtask

  task automatic check_pixel(input string tag, input int h, input int v);
    h_count = 10'(h); v_count = 10'(v);
    #1;
    if (model_on(int'(pos), h, v))
      check({tag, ".rom_row"}, rom_row, v - box_y(int'(pos)));
    step();
    check({tag, ".cardon"}, cardon, model_on(int'(pos), h, v));
    check({tag, ".rgb"}, rgb, model_rgb(int'(pos), h, v));
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_st = 0; m_w = 0;
    check_fsm(tag);
    check({tag, ".cardon"}, cardon, 0);
    check({tag, ".rgb"}, rgb, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [PIX_W-1:0] line;
    for (int r = 0; r < CARD_H; r++) begin
      for (int c = 0; c < CARD_W; c++) begin
        back_rom[r][c*RGB_W +: RGB_W] = RGB_W'($urandom_range(7, 0));
        face_rom[r][c*RGB_W +: RGB_W] = back_rom[r][c*RGB_W +: RGB_W] ^ RGB_W'($urandom_range(7, 1));
      end
    end

    h_count = 10'd230; v_count = 10'd170;
    do_reset("reset");

    // Geometry scan of slot 5 and a margin around it, card face down.
    pos = 4'd5;
    for (int v = 165; v <= 257; v++)
      for (int h = 225; h <= 317; h++)
        check_pixel("scan", h, v);
    line = back_rom[0];
    check_pixel("corner", 230, 170);
    check("corner.back", rgb, line[2:0]);

    // Requests in wrong states, request plus tick, reveal wipe.
    apply("hide_in_hidden", 0, 1, 0, 0);
    apply("flip_with_tick", 1, 0, 0, 1);
    apply("flip_in_reveal", 1, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      apply($sformatf("reveal_tick%0d", k), 0, 0, 0, 1);
      if (k == 2) begin
        line = face_rom[0];
        check_pixel("wipe22.c21", 251, 170);
        check("wipe22.c21.face", rgb, line[21*RGB_W +: RGB_W]);
        line = back_rom[0];
        check_pixel("wipe22.c22", 252, 170);
        check("wipe22.c22.back", rgb, line[22*RGB_W +: RGB_W]);
        for (int h = 228; h <= 315; h++) check_pixel("wipe22.row", h, 190);
      end
    end

    // Hide beats match; reset in the middle of hiding.
    apply("hide_and_match", 0, 1, 1, 0);
    for (int k = 1; k <= 4; k++) apply($sformatf("hide_tick%0d", k), 0, 0, 0, 1);
    h_count = 10'd240; v_count = 10'd180;
    step();
    do_reset("reset_mid_hide");

    // Reveal again, lock as matched, then requests are ignored.
    apply("flip2", 1, 0, 0, 0);
    for (int k = 1; k <= 8; k++) apply("reveal2_tick", 0, 0, 0, 1);
    apply("match", 0, 0, 1, 0);
    apply("flip_in_matched", 1, 0, 0, 1);
    apply("hide_in_matched", 0, 1, 0, 0);
    check_pixel("matched.231", 231, 170);
    check_pixel("matched.230", 230, 170);
    for (int h = 228; h <= 315; h++) check_pixel("matched.row", h, 200);
    do_reset("reset2");

    // Randomized mix of requests, ticks, slot changes, pixels and resets.
    for (int i = 0; i < 4000; i++) begin
      int sel;
      sel = $urandom_range(99, 0);
      if (sel < 2) begin
        do_reset("rnd_reset");
      end else if (sel < 45) begin
        apply("rnd_req", 1'($urandom_range(3, 0) == 0), 1'($urandom_range(3, 0) == 0),
              1'($urandom_range(7, 0) == 0), 1'($urandom_range(1, 0)));
      end else if (sel < 50) begin
        pos = 4'($urandom_range(15, 0));
      end else begin
        check_pixel("rnd_pix",
                    box_x(int'(pos)) - 3 + $urandom_range(CARD_W + 5, 0),
                    box_y(int'(pos)) - 3 + $urandom_range(CARD_H + 5, 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
